// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the network result collector.
package nn_pkg;

  localparam int W_DEFAULT = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/nn_result_collector_if.sv
// Handshake bundle between the collector, the upstream network and the
// result consumer. master = collector side, slave = environment side.
interface nn_result_collector_if #(
  parameter int W = nn_pkg::W_DEFAULT
);

  logic                     go;
  logic                     nn_start;
  logic [nn_pkg::IDX_W-1:0] nn_sel;
  logic                     nn_ready;
  logic [W-1:0]             nn_out;
  logic [nn_pkg::IDX_W-1:0] class_idx;
  logic [W-1:0]             class_score;
  logic                     class_valid;
  logic                     class_accept;
  logic                     busy;

  modport master (
    input  go, nn_ready, nn_out, class_accept,
    output nn_start, nn_sel, class_idx, class_score, class_valid, busy
  );

  modport slave (
    output go, nn_ready, nn_out, class_accept,
    input  nn_start, nn_sel, class_idx, class_score, class_valid, busy
  );

endinterface

// File: rtl/argmax_tracker.sv
// Running argmax over signed scores: init loads unconditionally, update
// replaces only on a strictly greater score so ties keep the lower index.
module argmax_tracker #(
  parameter int W = nn_pkg::W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     update,
  input  logic signed [W-1:0]      din,
  input  logic [nn_pkg::IDX_W-1:0] idx,
  output logic signed [W-1:0]      best_score,
  output logic [nn_pkg::IDX_W-1:0] best_idx
);

  logic signed [W-1:0]      score_q, score_d;
  logic [nn_pkg::IDX_W-1:0] idx_q, idx_d;

  // Best-so-far registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      idx_q   <= '0;
    end else begin
      score_q <= score_d;
      idx_q   <= idx_d;
    end
  end

  // Load on init, otherwise replace on a strictly greater signed score.
  always_comb begin
    score_d = score_q;
    idx_d   = idx_q;
    if (init) begin
      score_d = din;
      idx_d   = '0;
    end else if (update && (din > score_q)) begin
      score_d = din;
      idx_d   = idx;
    end
  end

  assign best_score = score_q;
  assign best_idx   = idx_q;

endmodule

// File: rtl/nn_result_collector.sv
// Sequences N_CLASSES network runs, one per class, and reports the argmax
// class and its score until the consumer accepts it.
module nn_result_collector #(
  parameter int N_CLASSES = 10,
  parameter int W         = nn_pkg::W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  nn_result_collector_if.master bus
);

  import nn_pkg::*;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_CLASSES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             rdy_q, rdy_d;
  logic             capture;
  logic signed [W-1:0] best_score;
  logic [IDX_W-1:0]    best_idx;

  // Only a fresh rising edge of nn_ready counts, so a level left high by the
  // previous run cannot complete the current one.
  assign capture = (state_q == S_WAIT) && bus.nn_ready && !rdy_q;
  assign rdy_d   = bus.nn_ready;

  // State, class counter and nn_ready history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state and class counter logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = S_ISSUE;
          k_d     = '0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (capture) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            k_d     = k_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.class_accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    bus.nn_start    = (state_q == S_ISSUE);
    bus.class_valid = (state_q == S_DONE);
    bus.busy        = (state_q != S_IDLE);
  end

  assign bus.nn_sel      = k_q;
  assign bus.class_idx   = best_idx;
  assign bus.class_score = best_score;

  argmax_tracker #(
    .W (W)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .init       (capture && (k_q == '0)),
    .update     (capture && (k_q != '0)),
    .din        (bus.nn_out),
    .idx        (k_q),
    .best_score (best_score),
    .best_idx   (best_idx)
  );

endmodule

// File: tb/tb_nn_result_collector.sv
// Directed bench for nn_result_collector with a variable-latency network model.
module tb_nn_result_collector;

  logic clk = 1'b0;
  logic rst;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  nn_result_collector_if #(.W(16)) bus ();

  nn_result_collector #(
    .N_CLASSES (4),
    .W         (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Network model state
  logic [15:0] scores [16];
  logic [3:0]  sel_log [64];
  int unsigned n_starts = 0;
  int unsigned wide_starts = 0;
  int unsigned lat_cnt = 0;
  logic        pending = 1'b0;
  logic        prev_start = 1'b0;
  logic [15:0] cur_score = '0;

  // Network: latches the class score on nn_start, raises nn_ready after
  // 3..20 cycles and holds it (and nn_out) until the next nn_start.
  always @(posedge clk) begin
    if (rst) begin
      bus.nn_ready <= 1'b0;
      bus.nn_out   <= 16'hDEAD;
      pending      <= 1'b0;
      prev_start   <= 1'b0;
    end else begin
      prev_start <= bus.nn_start;
      if (bus.nn_start && prev_start) wide_starts <= wide_starts + 1;
      if (bus.nn_start) begin
        sel_log[n_starts[5:0]] <= bus.nn_sel;
        n_starts     <= n_starts + 1;
        bus.nn_ready <= 1'b0;
        bus.nn_out   <= 16'($urandom);
        pending      <= 1'b1;
        lat_cnt      <= $urandom_range(20, 3);
        cur_score    <= scores[bus.nn_sel];
      end else if (pending) begin
        if (lat_cnt <= 1) begin
          bus.nn_ready <= 1'b1;
          bus.nn_out   <= cur_score;
          pending      <= 1'b0;
        end else begin
          lat_cnt    <= lat_cnt - 1;
          bus.nn_out <= 16'($urandom);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_scores(input logic [15:0] s0, s1, s2, s3);
    scores[0] = s0; scores[1] = s1; scores[2] = s2; scores[3] = s3;
  endtask

  task automatic pulse_go(input string tag);
    @(negedge clk);
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    chk({tag, "_start_lat"}, 32'(bus.nn_start), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 400 && !bus.class_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.class_valid), 32'd1);
  endtask

  task automatic run_check(input string tag, input logic [3:0] eidx, input logic [15:0] escore);
    int unsigned base;
    base = n_starts;
    pulse_go(tag);
    wait_valid(tag);
    chk({tag, "_idx"}, 32'(bus.class_idx), 32'(eidx));
    chk({tag, "_score"}, 32'(bus.class_score), 32'(escore));
    chk({tag, "_nstarts"}, n_starts - base, 32'd4);
    for (int i = 0; i < 4; i++)
      chk({tag, "_sel"}, 32'(sel_log[base + i]), 32'(i));
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    bus.class_accept = 1'b1;
    @(posedge clk);
    #1;
    bus.class_accept = 1'b0;
    chk({tag, "_acc_valid"}, 32'(bus.class_valid), 32'd0);
    chk({tag, "_acc_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int unsigned base;
    int unsigned snap;
    rst = 1'b1;
    bus.go = 1'b0;
    bus.class_accept = 1'b0;
    set_scores(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.class_valid), 32'd0);
    chk("rst_start", 32'(bus.nn_start), 32'd0);
    chk("rst_sel", 32'(bus.nn_sel), 32'd0);
    chk("rst_idx", 32'(bus.class_idx), 32'd0);
    chk("rst_score", 32'(bus.class_score), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Distinct maximum in the middle
    set_scores(16'h0010, 16'hFFF0, 16'h0200, 16'h0050);
    run_check("max", 4'd2, 16'h0200);
    accept("max");

    // Tie at the maximum keeps the lower index
    set_scores(16'h0005, 16'h0007, 16'h0007, 16'h0001);
    run_check("tie", 4'd1, 16'h0007);
    accept("tie");

    // All-negative scores, then hold DONE 10 cycles with go pulsed
    set_scores(16'hFFFD, 16'hFFFF, 16'hFFF8, 16'hFFFE);
    run_check("neg", 4'd1, 16'hFFFF);
    snap = n_starts;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.go = (i == 4);
      chk("hold_valid", 32'(bus.class_valid), 32'd1);
      chk("hold_idx", 32'(bus.class_idx), 32'd1);
      chk("hold_score", 32'(bus.class_score), 32'hFFFF);
    end
    bus.go = 1'b1;
    bus.class_accept = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    bus.class_accept = 1'b0;
    chk("accgo_valid", 32'(bus.class_valid), 32'd0);
    chk("accgo_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("accgo_idle", 32'(bus.busy), 32'd0);
    chk("accgo_nostart", n_starts - snap, 32'd0);
    chk("start_width", wide_starts, 32'd0);

    // Reset mid-run after two captures, then a clean run
    set_scores(16'h0010, 16'hFFF0, 16'h0200, 16'h0050);
    base = n_starts;
    pulse_go("mid");
    for (int i = 0; i < 400 && (n_starts - base) < 3; i++) @(negedge clk);
    chk("mid_reach", n_starts - base, 32'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_valid", 32'(bus.class_valid), 32'd0);
    chk("arst_start", 32'(bus.nn_start), 32'd0);
    chk("arst_sel", 32'(bus.nn_sel), 32'd0);
    chk("arst_idx", 32'(bus.class_idx), 32'd0);
    chk("arst_score", 32'(bus.class_score), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    set_scores(16'h0001, 16'h0003, 16'h0002, 16'h0000);
    run_check("post", 4'd1, 16'h0003);
    accept("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
